jtdsp16_do_ctrl: RTL and testbench

Sequencer for the DSP16 instruction cache used by the "do K { N instr }" and "redo K" loops. It captures the N instruction words on their first pass from ROM, then replays them K-1 more times from the cache while holding the program counter. It sits between the instruction decoder (which issues do_start/do_data) and the fetch path (PC/XAAU and the decoder's instruction input mux). Interrupts are masked while a loop is active.

---
 rtl/jtdsp16_do_ctrl_if.sv | 44 ++++
 rtl/jtdsp16_do_ctrl.sv | 146 ++++++++++++++
 tb/tb_jtdsp16_do_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/jtdsp16_do_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : jtdsp16_do_ctrl_if
//  Brief    : Decoder/fetch-side bundle of the DSP16 do/redo sequencer.
//             The master side is the decoder and fetch path.
//             The slave side is jtdsp16_do_ctrl.
//             The cloop signal exists only when JTDSP16_DO_CLOOP_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
interface jtdsp16_do_ctrl_if #(
    parameter int KW = 7
);
    logic             do_start;
    logic [KW+3:0]    do_data;      // [KW+3:KW]=N (0 means redo), [KW-1:0]=K
    logic             ins_adv;
    logic [15:0]      rom_dout;
    logic             cache_sel;
    logic [15:0]      cache_dout;
    logic             do_halt;
    logic             busy;
    logic             done;
`ifdef JTDSP16_DO_CLOOP_EN
    logic [KW-1:0]    cloop;

    modport master (
        output do_start, do_data, ins_adv, rom_dout,
        input  cache_sel, cache_dout, do_halt, busy, done, cloop
    );
    modport slave (
        input  do_start, do_data, ins_adv, rom_dout,
        output cache_sel, cache_dout, do_halt, busy, done, cloop
    );
`else
    modport master (
        output do_start, do_data, ins_adv, rom_dout,
        input  cache_sel, cache_dout, do_halt, busy, done
    );
    modport slave (
        input  do_start, do_data, ins_adv, rom_dout,
        output cache_sel, cache_dout, do_halt, busy, done
    );
`endif
endinterface
`default_nettype wire

// File: rtl/jtdsp16_do_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : jtdsp16_do_ctrl
//  Brief    : Instruction-cache sequencer for DSP16 "do K {N instr}" / "redo K".
//             The first pass is captured from ROM.
//             The block is then replayed K-1 times from the cache.
//             The PC is held while the block is replayed.
//             Optional macro JTDSP16_DO_CLOOP_EN adds the cloop output.
//             cloop gives the iterations remaining, and reads 0 when idle.
//  Revision : 1.0  initial release
// ============================================================================
module jtdsp16_do_ctrl #(
    parameter int CW = 4,           // cache address width, depth 2**CW-1
    parameter int KW = 7            // iteration count width
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              cen,
    jtdsp16_do_ctrl_if.slave       bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        LOOP = 2'd2
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   addr_q;
    logic [KW-1:0]   cnt_q;
    logic [3:0]      ni_q;
    logic            cache_sel_q;
    logic            do_halt_q;
    logic            busy_q;
    logic            done_q;
    logic [15:0]     mem_q [0:(2**CW)-2];

    logic [3:0]      w_n;
    logic [KW-1:0]   w_k;
    logic            w_last;
    logic            w_cnt_one;

    assign w_n       = bus.do_data[KW+3:KW];
    // A K of zero runs the block once, same as K=1
    assign w_k       = (bus.do_data[KW-1:0] == '0) ? KW'(1) : bus.do_data[KW-1:0];
    assign w_last    = (addr_q == CW'(ni_q - 4'd1));
    assign w_cnt_one = (cnt_q == KW'(1));

    // Capture ROM words on the first pass; the RAM is not reset
    always_ff @(posedge clk) begin
        if (cen && bus.ins_adv && state_q == LOAD) begin
            mem_q[addr_q] <= bus.rom_dout;
        end
    end

    // Loop sequencer: state, counters and registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            ni_q        <= '0;
            cache_sel_q <= 1'b0;
            do_halt_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else if (cen) begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.do_start) begin
                        if (w_n != 4'd0) begin
                            ni_q    <= w_n;
                            cnt_q   <= w_k;
                            addr_q  <= '0;
                            busy_q  <= 1'b1;
                            state_q <= LOAD;
                        end else if (ni_q != 4'd0) begin
                            // redo: replay the block already in the cache
                            cnt_q       <= w_k;
                            addr_q      <= '0;
                            busy_q      <= 1'b1;
                            cache_sel_q <= 1'b1;
                            do_halt_q   <= 1'b1;
                            state_q     <= LOOP;
                        end else begin
                            // redo with no block captured since reset
                            done_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (bus.ins_adv) begin
                        if (w_last) begin
                            addr_q <= '0;
                            if (w_cnt_one) begin
                                cnt_q   <= '0;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= IDLE;
                            end else begin
                                cnt_q       <= cnt_q - KW'(1);
                                cache_sel_q <= 1'b1;
                                do_halt_q   <= 1'b1;
                                state_q     <= LOOP;
                            end
                        end else begin
                            addr_q <= addr_q + CW'(1);
                        end
                    end
                end
                LOOP: begin
                    if (bus.ins_adv) begin
                        if (w_last) begin
                            addr_q <= '0;
                            if (w_cnt_one) begin
                                cnt_q       <= '0;
                                busy_q      <= 1'b0;
                                done_q      <= 1'b1;
                                cache_sel_q <= 1'b0;
                                do_halt_q   <= 1'b0;
                                state_q     <= IDLE;
                            end else begin
                                cnt_q <= cnt_q - KW'(1);
                            end
                        end else begin
                            addr_q <= addr_q + CW'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cache_sel  = cache_sel_q;
    assign bus.cache_dout = mem_q[addr_q];
    assign bus.do_halt    = do_halt_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
`ifdef JTDSP16_DO_CLOOP_EN
    assign bus.cloop      = cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_jtdsp16_do_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jtdsp16_do_ctrl
//  Brief    : Self-checking bench for jtdsp16_do_ctrl.
//             Every word the decoder takes is compared against a scoreboard
//             queue. Checks cloop when JTDSP16_DO_CLOOP_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module tb_jtdsp16_do_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cen = 1'b0;

    jtdsp16_do_ctrl_if bus_if ();

    jtdsp16_do_ctrl dut (
        .clk (clk),
        .rst (rst),
        .cen (cen),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] word;
        logic        sel;
        logic [6:0]  cl;
    } exp_t;

    typedef struct {
        int n;
        int k;
        bit cen_tog;
        int inj;        // inject a do_start after this many words (0: none)
        int total;      // hand-computed N*max(K,1), or 0 for a discarded redo
        bit busy1;      // busy expected right after the start cycle
    } vec_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   pc = 0;
    int   words = 0;
    int   done_cnt = 0;
    bit   done_prev = 1'b0;
    int   blk_base = 0;
    int   blk_n = 0;

    function automatic logic [15:0] rom(input int a);
        return 16'hC000 + 16'(a * 7);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic consume();
        exp_t e;
        logic [15:0] seen;
        seen = bus_if.cache_sel ? bus_if.cache_dout : bus_if.rom_dout;
        words++;
        if (sbq.size() == 0) begin
            chk("unexpected_word", 32'(seen), 32'hFFFF_FFFF);
        end else begin
            e = sbq.pop_front();
            chk("word", 32'(seen), 32'(e.word));
            chk("cache_sel", 32'(bus_if.cache_sel), 32'(e.sel));
`ifdef JTDSP16_DO_CLOOP_EN
            chk("cloop", 32'(bus_if.cloop), 32'(e.cl));
`endif
        end
    endtask

    // One clock: drive at negedge, take the word before posedge, track PC after
    task automatic cyc(input bit c, input bit ia, input bit ds, input logic [10:0] dd);
        bit adv;
        @(negedge clk);
        cen              = c;
        bus_if.ins_adv   = ia;
        bus_if.do_start  = ds;
        bus_if.do_data   = dd;
        #1;
        if (c && ia) consume();
        adv = c && ia && !bus_if.do_halt;
        @(posedge clk);
        #1;
        if (adv) begin
            pc++;
            bus_if.rom_dout = rom(pc);
        end
        if (bus_if.done && !done_prev) done_cnt++;
        done_prev = bus_if.done;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        cen = 1'b1;
        bus_if.ins_adv  = 1'b0;
        bus_if.do_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cache_sel", 32'(bus_if.cache_sel), 0);
        chk("rst_do_halt", 32'(bus_if.do_halt), 0);
        chk("rst_busy", 32'(bus_if.busy), 0);
        chk("rst_done", 32'(bus_if.done), 0);
`ifdef JTDSP16_DO_CLOOP_EN
        chk("rst_cloop", 32'(bus_if.cloop), 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        done_prev = 1'b0;
        blk_n = 0;
        sbq.delete();
    endtask

    task automatic push_block(input int n, input int k);
        int kk;
        kk = (k == 0) ? 1 : k;
        if (n != 0) begin
            blk_base = pc;
            blk_n    = n;
            for (int it = 0; it < kk; it++)
                for (int j = 0; j < n; j++)
                    sbq.push_back('{rom(blk_base + j), (it != 0), 7'(kk - it)});
        end else if (blk_n != 0) begin
            for (int it = 0; it < kk; it++)
                for (int j = 0; j < blk_n; j++)
                    sbq.push_back('{rom(blk_base + j), 1'b1, 7'(kk - it)});
        end
    endtask

    task automatic run_vec(input vec_t v);
        bit c;
        bit inj;
        bit injected;
        push_block(v.n, v.k);
        words    = 0;
        done_cnt = 0;
        injected = 1'b0;
        cyc(1'b1, 1'b0, 1'b1, {4'(v.n), 7'(v.k)});
        chk("busy_after_start", 32'(bus_if.busy), 32'(v.busy1));
        for (int c2 = 0; c2 < 400 && done_cnt == 0; c2++) begin
            c   = v.cen_tog ? (c2 % 2 == 1) : 1'b1;
            inj = c && (v.inj > 0) && (words == v.inj) && !injected;
            if (inj) injected = 1'b1;
            cyc(c, 1'b1, inj, inj ? {4'd5, 7'd7} : 11'd0);
        end
        chk("done_seen", 32'(done_cnt), 1);
        chk("total_words", 32'(words), 32'(v.total));
        chk("queue_empty", 32'(sbq.size()), 0);
        chk("end_busy", 32'(bus_if.busy), 0);
        chk("end_cache_sel", 32'(bus_if.cache_sel), 0);
        chk("end_do_halt", 32'(bus_if.do_halt), 0);
`ifdef JTDSP16_DO_CLOOP_EN
        chk("end_cloop", 32'(bus_if.cloop), 0);
`endif
        sbq.delete();
        cyc(1'b1, 1'b0, 1'b0, 11'd0);
        chk("done_one_cycle", 32'(bus_if.done), 0);
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{0,  5, 1'b0, 0, 0,  1'b0};  // redo after reset: discarded
        vecs[1] = '{3,  4, 1'b0, 0, 12, 1'b1};
        vecs[2] = '{2,  1, 1'b0, 0, 2,  1'b1};
        vecs[3] = '{2,  0, 1'b0, 0, 2,  1'b1};  // K=0 behaves as K=1
        vecs[4] = '{0,  3, 1'b0, 0, 6,  1'b1};  // redo of the 2-word block
        vecs[5] = '{15, 2, 1'b1, 0, 30, 1'b1};  // cen toggling, full cache
        vecs[6] = '{3,  3, 1'b0, 4, 9,  1'b1};  // do_start mid-LOOP ignored

        bus_if.do_start = 1'b0;
        bus_if.do_data  = '0;
        bus_if.ins_adv  = 1'b0;
        bus_if.rom_dout = rom(0);

        do_reset();
        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Reset in the middle of a replay aborts at once
        push_block(2, 3);
        words    = 0;
        done_cnt = 0;
        cyc(1'b1, 1'b0, 1'b1, {4'd2, 7'd3});
        for (int c2 = 0; c2 < 50 && words < 3; c2++) cyc(1'b1, 1'b1, 1'b0, 11'd0);
        chk("midloop_halt_before_rst", 32'(bus_if.do_halt), 1);
        @(negedge clk);
        rst = 1'b1;
        bus_if.ins_adv = 1'b0;
        @(posedge clk);
        #1;
        chk("midloop_rst_cache_sel", 32'(bus_if.cache_sel), 0);
        chk("midloop_rst_do_halt", 32'(bus_if.do_halt), 0);
        chk("midloop_rst_busy", 32'(bus_if.busy), 0);
        @(negedge clk);
        rst = 1'b0;
        done_prev = 1'b0;
        blk_n = 0;
        sbq.delete();

        // A redo after that reset has no block to replay
        run_vec('{0, 5, 1'b0, 0, 0, 1'b0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
